// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the serial IRAM boot loader: sync byte, FSM encodings
// and small datapath helpers.
package imem_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loadState_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_t;

  function automatic logic isBusy(input loadState_t s);
    case (s)
      IDLE, DONE, ERR: isBusy = 1'b0;
      default:         isBusy = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] csumStep(input logic [7:0] acc, input logic [7:0] b);
    csumStep = acc ^ b;
  endfunction

endpackage

// File: rtl/imem_boot_loader_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer; start bits are
// confirmed at mid-bit and the stop bit is checked at mid-bit.
module uart_rx_byte
  import imem_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rxMeta_r, rxSync_r, rxPrev_r;
  rxState_t         rxState_r, rxStateNext_s;
  logic [CNT_W-1:0] cnt_r, cntNext_s;
  logic [2:0]       bitIdx_r, bitIdxNext_s;
  logic [7:0]       shift_r, shiftNext_s;
  logic             validNext_s, ferrNext_s;
  logic             byteValid_r, framingErr_r;
  logic [7:0]       byteData_r;

  // Input synchronizer and edge history; resets to the idle-high line level
  always_ff @(posedge clock) begin
    if (!clear) begin
      rxMeta_r <= 1'b1;
      rxSync_r <= 1'b1;
      rxPrev_r <= 1'b1;
    end else begin
      rxMeta_r <= rx;
      rxSync_r <= rxMeta_r;
      rxPrev_r <= rxSync_r;
    end
  end

  // Receiver next-state, bit timing and output pulse decode
  always_comb begin
    rxStateNext_s = rxState_r;
    cntNext_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    bitIdxNext_s  = bitIdx_r;
    shiftNext_s   = shift_r;
    validNext_s   = 1'b0;
    ferrNext_s    = 1'b0;
    case (rxState_r)
      RX_IDLE: begin
        cntNext_s = '0;
        if (rxPrev_r && !rxSync_r) rxStateNext_s = RX_START;
        else                       rxStateNext_s = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_CNT) begin
          cntNext_s    = '0;
          bitIdxNext_s = 3'd0;
          // A line that is high again at mid-start was only a glitch
          if (rxSync_r) rxStateNext_s = RX_IDLE;
          else          rxStateNext_s = RX_DATA;
        end else begin
          rxStateNext_s = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_r == LAST_CNT) begin
          cntNext_s    = '0;
          shiftNext_s  = {rxSync_r, shift_r[7:1]};
          bitIdxNext_s = bitIdx_r + 3'd1;
          if (bitIdx_r == 3'd7) rxStateNext_s = RX_STOP;
          else                  rxStateNext_s = RX_DATA;
        end else begin
          rxStateNext_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_r == LAST_CNT) begin
          cntNext_s     = '0;
          rxStateNext_s = RX_IDLE;
          if (rxSync_r) validNext_s = 1'b1;
          else          ferrNext_s  = 1'b1;
        end else begin
          rxStateNext_s = RX_STOP;
        end
      end
      default: begin
        rxStateNext_s = RX_IDLE;
        cntNext_s     = '0;
      end
    endcase
  end

  // Receiver state and registered outputs
  always_ff @(posedge clock) begin
    if (!clear) begin
      rxState_r    <= RX_IDLE;
      cnt_r        <= '0;
      bitIdx_r     <= 3'd0;
      shift_r      <= 8'h00;
      byteValid_r  <= 1'b0;
      byteData_r   <= 8'h00;
      framingErr_r <= 1'b0;
    end else begin
      rxState_r    <= rxStateNext_s;
      cnt_r        <= cntNext_s;
      bitIdx_r     <= bitIdxNext_s;
      shift_r      <= shiftNext_s;
      byteValid_r  <= validNext_s;
      framingErr_r <= ferrNext_s;
      if (validNext_s) byteData_r <= shift_r;
    end
  end

  assign byte_valid  = byteValid_r;
  assign byte_data   = byteData_r;
  assign framing_err = framingErr_r;

endmodule

// File: rtl/imem_boot_loader.sv
// Serial boot loader: parses a sync/length/payload/checksum UART frame, writes
// little-endian words into IRAM and releases the core once the image checks out.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int BOOT_HOLD    = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rx,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              core_clear,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_WORDS      = 17'd1 << ADDR_W;
  localparam logic        CORE_CLEAR_RST = (BOOT_HOLD == 0) ? 1'b1 : 1'b0;

  logic        byteValid_s, framingErr_s;
  logic [7:0]  byteData_s;

  loadState_t        state_r, stateNext_s;
  logic [15:0]       len_r, lenNext_s;
  logic [31:0]       word_r, wordNext_s;
  logic [1:0]        byteIdx_r, byteIdxNext_s;
  logic [7:0]        csum_r, csumNext_s;
  logic              imemWren_r, imemWrenNext_s;
  logic [ADDR_W-1:0] imemAddr_r, imemAddrNext_s;
  logic [31:0]       imemDin_r, imemDinNext_s;
  logic              coreClear_r, coreClearNext_s;
  logic              busy_r;
  logic              error_r, errorNext_s;
  logic [ADDR_W:0]   wordsLoaded_r, wordsLoadedNext_s;
  logic [ADDR_W:0]   wordsInc_s;
  logic [15:0]       lenFull_s;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .clear      (clear),
    .rx         (rx),
    .byte_valid (byteValid_s),
    .byte_data  (byteData_s),
    .framing_err(framingErr_s)
  );

  assign wordsInc_s = wordsLoaded_r + {{ADDR_W{1'b0}}, 1'b1};
  assign lenFull_s  = {byteData_s, len_r[7:0]};

  // Frame parser: next state, word assembly, checksum and IRAM write decode
  always_comb begin
    stateNext_s       = state_r;
    lenNext_s         = len_r;
    wordNext_s        = word_r;
    byteIdxNext_s     = byteIdx_r;
    csumNext_s        = csum_r;
    imemWrenNext_s    = 1'b0;
    imemAddrNext_s    = imemAddr_r;
    imemDinNext_s     = imemDin_r;
    coreClearNext_s   = coreClear_r;
    errorNext_s       = error_r;
    wordsLoadedNext_s = wordsLoaded_r;
    if (byteValid_s) begin
      case (state_r)
        IDLE, DONE, ERR: begin
          if (byteData_s == SYNC_BYTE) begin
            stateNext_s       = LEN_LO;
            coreClearNext_s   = 1'b0;
            errorNext_s       = 1'b0;
            wordsLoadedNext_s = '0;
          end else begin
            stateNext_s = state_r;
          end
        end
        LEN_LO: begin
          lenNext_s[7:0] = byteData_s;
          stateNext_s    = LEN_HI;
        end
        LEN_HI: begin
          lenNext_s  = lenFull_s;
          csumNext_s = 8'h00;
          // Oversized images are rejected here, so addresses can never wrap
          if ({1'b0, lenFull_s} > MAX_WORDS) begin
            stateNext_s     = ERR;
            errorNext_s     = 1'b1;
            coreClearNext_s = 1'b0;
          end else if (lenFull_s == 16'd0) begin
            stateNext_s = CSUM;
          end else begin
            stateNext_s       = DATA;
            byteIdxNext_s     = 2'd0;
            wordsLoadedNext_s = '0;
            imemAddrNext_s    = '0;
          end
        end
        DATA: begin
          wordNext_s    = {byteData_s, word_r[31:8]};
          csumNext_s    = csumStep(csum_r, byteData_s);
          byteIdxNext_s = byteIdx_r + 2'd1;
          if (byteIdx_r == 2'd3) begin
            imemWrenNext_s    = 1'b1;
            imemAddrNext_s    = wordsLoaded_r[ADDR_W-1:0];
            imemDinNext_s     = wordNext_s;
            wordsLoadedNext_s = wordsInc_s;
            if (17'(wordsInc_s) == {1'b0, len_r}) stateNext_s = CSUM;
            else                                  stateNext_s = DATA;
          end else begin
            stateNext_s = DATA;
          end
        end
        CSUM: begin
          if (byteData_s == csum_r) begin
            stateNext_s     = DONE;
            coreClearNext_s = 1'b1;
          end else begin
            stateNext_s     = ERR;
            errorNext_s     = 1'b1;
            coreClearNext_s = 1'b0;
          end
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end else if (framingErr_s) begin
      if (isBusy(state_r)) begin
        stateNext_s     = ERR;
        errorNext_s     = 1'b1;
        coreClearNext_s = 1'b0;
      end else begin
        stateNext_s = state_r;
      end
    end else begin
      stateNext_s = state_r;
    end
  end

  // Parser state and registered IRAM/core-control outputs
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r       <= IDLE;
      len_r         <= 16'h0000;
      word_r        <= 32'h0000_0000;
      byteIdx_r     <= 2'd0;
      csum_r        <= 8'h00;
      imemWren_r    <= 1'b0;
      imemAddr_r    <= '0;
      imemDin_r     <= 32'h0000_0000;
      coreClear_r   <= CORE_CLEAR_RST;
      busy_r        <= 1'b0;
      error_r       <= 1'b0;
      wordsLoaded_r <= '0;
    end else begin
      state_r       <= stateNext_s;
      len_r         <= lenNext_s;
      word_r        <= wordNext_s;
      byteIdx_r     <= byteIdxNext_s;
      csum_r        <= csumNext_s;
      imemWren_r    <= imemWrenNext_s;
      imemAddr_r    <= imemAddrNext_s;
      imemDin_r     <= imemDinNext_s;
      coreClear_r   <= coreClearNext_s;
      busy_r        <= isBusy(stateNext_s);
      error_r       <= errorNext_s;
      wordsLoaded_r <= wordsLoadedNext_s;
    end
  end

  assign imem_wren    = imemWren_r;
  assign imem_addr    = imemAddr_r;
  assign imem_din     = imemDin_r;
  assign core_clear   = coreClear_r;
  assign busy         = busy_r;
  assign error        = error_r;
  assign words_loaded = wordsLoaded_r;

endmodule
